// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter and sequencer for a shared 4:1 data multiplexer. One requester is
// granted at a time. Its beats go to a single consumer over a valid/ready handshake.
// Priority rotates after every packet, and a grant is capped at MAX_BEATS beats.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req[3:0]   per-requester request, held while beats remain
//   i_last[3:0]  per-requester end-of-packet flag for the current beat
//   i_din        packed requester data, requester k at [k*W +: W]
//   i_out_ready  downstream accepts a beat this cycle
//   o_out_valid  o_out_data holds a valid beat
//   o_out_data   beat from the selected requester
//   o_out_last   last flag of the granted requester, 0 when idle
//   o_gnt[3:0]   one-hot grant, zero when idle
//   o_sel[1:0]   mux select (granted requester index)
//   o_busy       high while a grant is active
module mux4_rr_arbiter #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [3:0]     i_req,
  input  logic [3:0]     i_last,
  input  logic [4*W-1:0] i_din,
  input  logic           i_out_ready,
  output logic           o_out_valid,
  output logic [W-1:0]   o_out_data,
  output logic           o_out_last,
  output logic [3:0]     o_gnt,
  output logic [1:0]     o_sel,
  output logic           o_busy
);

  localparam int unsigned CW = $clog2(MAX_BEATS) + 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        r_state, w_state_d;
  logic [1:0]    r_ptr, w_ptr_d;
  logic [1:0]    r_sel, w_sel_d;
  logic [CW-1:0] r_cnt, w_cnt_d;

  logic          w_found;
  logic [1:0]    w_pick;
  logic [1:0]    w_idx;
  logic          w_xfer;
  logic          w_release;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_sel   <= w_sel_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // First asserted requester, searching from r_ptr upward with wrap. The loop runs from
  // the far end, so the nearest hit is the one left in w_pick.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (i_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_xfer = (r_state == StGrant) && i_req[r_sel] && i_out_ready;

  // Release on the last beat or the beat cap (a single release when both hold), or when
  // the granted requester withdraws without transferring.
  assign w_release = (r_state == StGrant) &&
                     ((w_xfer && (i_last[r_sel] || (r_cnt == CW'(MAX_BEATS - 1)))) ||
                      !i_req[r_sel]);

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_sel_d   = r_sel;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StGrant;
          w_sel_d   = w_pick;
          w_cnt_d   = '0;
        end
      end
      StGrant: begin
        if (w_release) begin
          // No re-arbitration here; the mandatory idle cycle follows.
          w_state_d = StIdle;
          w_ptr_d   = r_sel + 2'd1;
          w_cnt_d   = '0;
        end else if (w_xfer) begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs. These are combinational from the registered state/select and the live inputs.
  always_comb begin
    o_busy      = (r_state == StGrant);
    o_sel       = r_sel;
    o_gnt       = o_busy ? (4'b0001 << r_sel) : 4'b0000;
    o_out_valid = o_busy && i_req[r_sel];
    o_out_last  = o_busy && i_last[r_sel];
    o_out_data  = i_din[r_sel*W +: W];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (W=8, MAX_BEATS=4).
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] din;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mux4_rr_arbiter #(.W(8), .MAX_BEATS(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_last      (last),
    .i_din       (din),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_gnt       (gnt),
    .o_sel       (sel),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int k, input logic [7:0] v);
    din[k*8 +: 8] = v;
  endtask

  initial begin
    // Reset with every requester asserted.
    rst_n = 1'b0; req = 4'b1111; last = 4'b0000; out_ready = 1'b1;
    din = 32'h44332211;
    #3;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_sel", sel, 2'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_data", out_data, 8'h11);
    step(); step();
    req = 4'b0000;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_busy", busy, 1'b0);
    end
    chk("idle_gnt", gnt, 4'b0000);

    // Single packet from requester 2.
    req = 4'b0100; set_din(2, 8'hA5);
    #1 chk("pkt_pre_busy", busy, 1'b0);
    step();
    chk("pkt_gnt", gnt, 4'b0100);
    chk("pkt_sel", sel, 2'd2);
    chk("pkt_b0", out_data, 8'hA5);
    chk("pkt_v0", out_valid, 1'b1);
    step();
    set_din(2, 8'h5A);
    #1 chk("pkt_b1", out_data, 8'h5A);
    chk("pkt_gnt1", gnt, 4'b0100);
    step();
    set_din(2, 8'h3C); last = 4'b0100;
    #1 chk("pkt_b2", out_data, 8'h3C);
    chk("pkt_last2", out_last, 1'b1);
    step();
    req = 4'b0000; last = 4'b0000;
    #1 chk("pkt_rel_gnt", gnt, 4'b0000);
    chk("pkt_rel_busy", busy, 1'b0);
    // Pointer is now 3, so requester 3 beats requester 0.
    req = 4'b1001;
    step();
    chk("ptr3_gnt", gnt, 4'b1000);
    last = 4'b1000;
    step();
    req = 4'b0000; last = 4'b0000;
    #1 chk("ptr3_rel", busy, 1'b0);

    // Rotation with all requesting, one-beat packets.
    req = 4'b1111; last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rot_gnt", gnt, 4'b0001 << (k % 4));
      chk("rot_valid", out_valid, 1'b1);
      step();
      chk("rot_bubble", busy, 1'b0);
    end
    req = 4'b0000; last = 4'b0000;

    // Backpressure on requester 1 (pointer is 1).
    req = 4'b0010; set_din(1, 8'h77);
    step();
    chk("bp_gnt", gnt, 4'b0010);
    chk("bp_d0", out_data, 8'h77);
    step();
    out_ready = 1'b0; set_din(1, 8'h88);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_sel", sel, 2'd1);
      chk("bp_gnt_hold", gnt, 4'b0010);
      chk("bp_data", out_data, 8'h88);
      step();
    end
    out_ready = 1'b1;
    // One beat so far, so three more reach the cap.
    step();
    chk("bp_busy2", busy, 1'b1);
    step();
    chk("bp_busy3", busy, 1'b1);
    step();
    chk("bp_rel", gnt, 4'b0000);
    req = 4'b0000;

    // Abort: pointer is 2, requester 0 wins the search over requester 1.
    req = 4'b0011; set_din(0, 8'h10);
    step();
    chk("ab_gnt", gnt, 4'b0001);
    step();
    req = 4'b0010;
    #1 chk("ab_valid", out_valid, 1'b0);
    step();
    chk("ab_rel", gnt, 4'b0000);
    step();
    chk("ab_next", gnt, 4'b0010);

    // Beat cap: requester 1 streams without last while requester 3 waits.
    req = 4'b1010;
    step();
    chk("cap_b1", gnt, 4'b0010);
    step();
    chk("cap_b2", gnt, 4'b0010);
    step();
    chk("cap_b3", gnt, 4'b0010);
    step();
    chk("cap_rel", gnt, 4'b0000);
    step();
    chk("cap_next", gnt, 4'b1000);

    // Reset during a grant: pointer returns to 0, so requester 1 wins next.
    rst_n = 1'b0;
    #1 chk("mrst_gnt", gnt, 4'b0000);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_sel", sel, 2'd0);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_data", out_data, 8'h10);
    #1 rst_n = 1'b1;
    step();
    chk("mrst_next", gnt, 4'b0010);
    chk("mrst_nsel", sel, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
